// File: rtl/sar_compare_search.sv
// sar_compare_search
// Successive-approximation controller for an external combinational
// magnitude comparator. It drives the B operand (probe), reads back the
// one-hot {eq,gt,lt} result and resolves one bit per clock, MSB first.
// The search stops early on an exact match. A comparator code that is not
// one-hot aborts the search with an error pulse.

module sar_compare_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       cmp_res,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_probe;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_eq;
    logic             w_gt;
    logic             w_lt;
    logic             w_idx_zero;
    logic [WIDTH-1:0] w_probe_resolved;
    logic [WIDTH-1:0] w_probe_next;

    // One-hot mask selecting a single probe bit
    function automatic logic [WIDTH-1:0] bit_mask(input logic [IDX_W-1:0] idx);
        return WIDTH'(1) << idx;
    endfunction

    // Decode the comparator result strictly; anything else is an error
    assign w_eq = (cmp_res == 3'b100);
    assign w_gt = (cmp_res == 3'b010);
    assign w_lt = (cmp_res == 3'b001);

    assign w_idx_zero = (r_idx == '0);

    // Trial bit stays set when A is larger, is cleared when A is smaller
    assign w_probe_resolved = w_lt ? (r_probe & ~bit_mask(r_idx)) : r_probe;

    // Next trial: keep resolved bits and set the next lower bit
    assign w_probe_next = w_probe_resolved | bit_mask(r_idx - IDX_W'(1));

    // Search FSM with registered outputs; done/err default low so they pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_probe  <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SEARCH;
                        r_probe <= bit_mask(IDX_W'(WIDTH - 1));
                        r_idx   <= IDX_W'(WIDTH - 1);
                        r_busy  <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (w_eq) begin
                        r_result <= r_probe;
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
                        r_probe  <= '0;
                        r_idx    <= '0;
                        r_busy   <= 1'b0;
                    end else if (w_gt || w_lt) begin
                        if (w_idx_zero) begin
                            r_result <= w_probe_resolved;
                            r_done   <= 1'b1;
                            r_state  <= IDLE;
                            r_probe  <= '0;
                            r_busy   <= 1'b0;
                        end else begin
                            r_probe <= w_probe_next;
                            r_idx   <= r_idx - IDX_W'(1);
                        end
                    end else begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
                        r_probe  <= '0;
                        r_idx    <= '0;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_probe <= '0;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign probe  = r_probe;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign err    = r_err;

endmodule

// File: tb/tb_sar_compare_search.sv
// tb_sar_compare_search
// Bench for the successive-approximation controller. A comparator against a
// hidden operand A answers the probe. A driver issues searches and pushes the
// expected outcome into a scoreboard. A monitor checks every busy cycle and
// every done pulse against it.

module tb_sar_compare_search;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   cmp_res;
    logic [W-1:0] probe;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;

    logic [W-1:0] a_val;
    logic         force_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] res;
        logic         e;
        int           lat;
        int           t0;
    } exp_t;

    exp_t sb[$];

    sar_compare_search #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cmp_res (cmp_res),
        .probe   (probe),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator: A against the probe, or a forced illegal code
    always_comb begin
        cmp_res = 3'b001;
        if (force_err)          cmp_res = 3'b011;
        else if (a_val == probe) cmp_res = 3'b100;
        else if (a_val > probe)  cmp_res = 3'b010;
    end

    // Cycles to find A: exact match as soon as the trial bit is A's lowest set bit
    function automatic int ref_latency(input logic [W-1:0] a);
        int tz;
        if (a == 0) return W;
        tz = 0;
        while (a[tz] == 1'b0) tz++;
        return W - tz;
    endfunction

    // Probe seen at step j: A's bits above the trial bit, trial bit set, rest 0
    function automatic logic [W-1:0] ref_probe(input logic [W-1:0] a, input int j);
        int av;
        int sh;
        av = int'(a);
        sh = W - j + 1;
        return W'(((av >> sh) << sh) | (1 << (W - j)));
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: per-cycle probe check while busy, outcome check on done
    always @(negedge clk) begin
        exp_t e;
        int   step;
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result", int'(result), int'(e.res));
                    chk("err", int'(err), int'(e.e));
                    chk("latency", cyc - e.t0, e.lat);
                    chk("probe_after_done", int'(probe), 0);
                    chk("busy_after_done", int'(busy), 0);
                end
            end else begin
                chk("err_without_done", int'(err), 0);
                if (busy) begin
                    if (sb.size() == 0) begin
                        chk("busy_without_search", 1, 0);
                    end else begin
                        e = sb[0];
                        step = cyc - e.t0 + 1;
                        if (step < 1 || step > W)
                            chk("search_overrun_step", step, W);
                        else
                            chk("probe", int'(probe), int'(ref_probe(e.a, step)));
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    // Issue one search, optionally with an illegal comparator code
    task automatic run_search(input logic [W-1:0] a, input logic ferr);
        exp_t e;
        wait_idle();
        a_val     = a;
        force_err = ferr;
        start     = 1'b1;
        e.a   = a;
        e.res = ferr ? '0 : a;
        e.e   = ferr;
        e.lat = ferr ? 1 : ref_latency(a);
        e.t0  = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        force_err = 1'b0;
    endtask

    initial begin
        int t0;
        exp_t e;
        int n;

        reset     = 1'b1;
        start     = 1'b0;
        a_val     = '0;
        force_err = 1'b0;
        #1;
        chk("reset_probe", int'(probe), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_err", int'(err), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases, including both operand extremes and an exact MSB hit
        run_search(4'd11, 1'b0);
        run_search(4'd0, 1'b0);
        run_search(4'd8, 1'b0);
        @(negedge clk);
        chk("busy_low_after_early_exit", int'(busy), 0);
        run_search(4'd15, 1'b0);
        run_search(4'd1, 1'b0);
        run_search(4'd9, 1'b1);
        run_search(4'd7, 1'b0);

        // Reset in the middle of a search aborts with no done pulse
        wait_idle();
        a_val = 4'd5;
        start = 1'b1;
        e.a = 4'd5; e.res = 4'd5; e.e = 1'b0; e.lat = ref_latency(4'd5); e.t0 = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_probe", int'(probe), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_result", int'(result), 0);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_search(4'd5, 1'b0);

        // Start pulsed again while busy is ignored
        wait_idle();
        a_val = 4'd6;
        start = 1'b1;
        e.a = 4'd6; e.res = 4'd6; e.e = 1'b0; e.lat = ref_latency(4'd6); e.t0 = cyc + 1;
        t0 = e.t0;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("no_restart_busy", int'(busy), 0);

        // Start held high: the next search begins on the first idle cycle
        a_val = 4'd3;
        start = 1'b1;
        t0 = cyc + 1;
        e.a = 4'd3; e.res = 4'd3; e.e = 1'b0; e.lat = ref_latency(4'd3); e.t0 = t0;
        sb.push_back(e);
        e.t0 = t0 + ref_latency(4'd3) + 1;
        sb.push_back(e);
        n = 0;
        while (cyc < t0 + ref_latency(4'd3) + 1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        wait_idle();

        // Randomized searches with occasional illegal comparator codes
        for (int i = 0; i < 60; i++) begin
            run_search(W'($urandom_range(0, (1 << W) - 1)), ($urandom_range(0, 9) == 0));
        end

        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
